count_ctrl: RTL and testbench
=============================

COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameters SHALL be: DIV0, default 50000000, tick period in CLK cycles for contral=00.
REQ-002 DIV1, default 5000000, tick period for contral=01.
REQ-003 DIV2, default 500000, tick period for contral=10.
REQ-004 DIV3, default 1, tick period for contral=11 (tick every cycle).
REQ-005 CLK  in  1  single clock; all logic on posedge CLK.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 contral  in  2  rate select for DIV0..DIV3.
REQ-008 start  in  1  level-sampled run request.
REQ-009 stop  in  1  level-sampled stop request.
REQ-010 load_req  in  1  preset request.
REQ-011 load_value  in  4  preset digit.
REQ-012 wrap_limit  in  4  number of 9->0 wraps before DONE; 0 = free-run.
REQ-013 tick  out  1  one-cycle count enable to the decade counter.
REQ-014 load_enable  out  1  one-cycle load strobe to the counter.
REQ-015 load_counter  out  4  value presented with load_enable.
REQ-016 cnt_clr  out  1  one-cycle clear strobe to the counter.
REQ-017 digit  out  4  shadow copy of counter value, 0..9.
REQ-018 wrap_cnt  out  4  wraps completed since last start from IDLE/DONE.
REQ-019 state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-020 load_err  out  1  one-cycle pulse on rejected load.

Function
REQ-021 All outputs SHALL be registered; strobes are high for exactly one CLK cycle.
REQ-022 Prescaler SHALL be a 26-bit counter, active only in RUN, that pulses tick and returns to 0 when prescaler >= DIVsel-1; otherwise it increments.
REQ-023 A contral change mid-count SHALL take effect on the next compare (the >= rule guarantees a tick the next cycle if already past).
REQ-024 On each tick, digit SHALL increment 0..8 -> +1 and 9 -> 0; the 9->0 step is a wrap, and wrap_cnt increments (saturating at 15).
REQ-025 IDLE: start -> RUN with prescaler=0, wrap_cnt=0; digit unchanged.
REQ-026 RUN: stop -> PAUSE, prescaler retained; a tick due in the same cycle as stop SHALL be suppressed.
REQ-027 RUN: on the wrap where wrap_limit!=0 and the new wrap_cnt equals wrap_limit -> DONE, with that tick still issued.
REQ-028 PAUSE: start -> RUN resuming the retained prescaler; stop -> IDLE, with cnt_clr pulsed and digit=0.
REQ-029 DONE: start -> RUN with prescaler=0, wrap_cnt=0; stop -> IDLE, with cnt_clr pulsed and digit=0.
REQ-030 start and stop high together: stop SHALL win.
REQ-031 load_req SHALL be honoured only in IDLE, PAUSE or DONE, and only when load_value<=9: load_enable=1, load_counter=load_value, digit=load_value the next cycle; state unchanged.
REQ-032 load_req in IDLE/PAUSE/DONE with load_value>9 SHALL pulse load_err, with no load_enable and digit unchanged.
REQ-033 load_req in RUN SHALL be ignored silently.
REQ-034 load_req in the same cycle as start/stop SHALL be ignored, and the state transition takes effect.
REQ-035 Latency: start sampled at edge n gives state=RUN after edge n; the first tick occurs DIVsel cycles after entering RUN from prescaler=0.

Reset
REQ-036 rst_n low SHALL asynchronously force state=IDLE, prescaler=0, digit=0, wrap_cnt=0, load_counter=0, and tick, load_enable, cnt_clr and load_err all 0.
REQ-037 Reset mid-RUN SHALL abort with no further tick; operation resumes only on start after rst_n deasserts, with first response one edge after release.

Verification (DIV0=8, DIV1=4, DIV2=2, DIV3=1)
REQ-038 Scenario: contral=01, start 1 cycle -> state=01, tick every 4th cycle, digit 0,1..9,0 with wrap_cnt=1 after 40 cycles.
REQ-039 Scenario: wrap_limit=2, contral=11 -> 20 ticks, then state=11 (DONE) with digit=0 and wrap_cnt=2; no 21st tick.
REQ-040 Scenario: in IDLE, load_value=7 then load_value=12 -> first gives load_enable pulse with load_counter=7 and digit=7; second gives load_err pulse only.
REQ-041 Scenario: RUN with contral=00, stop asserted on the cycle a tick is due -> no tick, state=10; start -> tick on the very next cycle.
REQ-042 Scenario: start and stop together in PAUSE -> state=00, cnt_clr pulse, digit=0.
REQ-043 Scenario: rst_n low mid-RUN between edges -> outputs are 0 immediately, with no tick after release until start.

Source files
------------

// File: rtl/count_ctrl_if.sv
// count_ctrl_if: control/status bundle between a controller host and count_ctrl.
//   Host -> count_ctrl : contral, start, stop, load_req, load_value, wrap_limit
//   count_ctrl -> host : tick, load_enable, load_counter, cnt_clr, digit,
//                        wrap_cnt, state, load_err
interface count_ctrl_if;
    logic [1:0] contral;
    logic       start;
    logic       stop;
    logic       load_req;
    logic [3:0] load_value;
    logic [3:0] wrap_limit;
    logic       tick;
    logic       load_enable;
    logic [3:0] load_counter;
    logic       cnt_clr;
    logic [3:0] digit;
    logic [3:0] wrap_cnt;
    logic [1:0] state;
    logic       load_err;

    // Host side: drives requests, observes status.
    modport master (
        output contral, start, stop, load_req, load_value, wrap_limit,
        input  tick, load_enable, load_counter, cnt_clr, digit, wrap_cnt, state, load_err
    );

    // Controller side.
    modport slave (
        input  contral, start, stop, load_req, load_value, wrap_limit,
        output tick, load_enable, load_counter, cnt_clr, digit, wrap_cnt, state, load_err
    );
endinterface

// File: rtl/count_ctrl.sv
// count_ctrl: rate-selectable tick generator and run/pause/done controller for
// a decade counter, keeping a shadow copy of the digit and a wrap count.
//   CLK   : clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : count_ctrl_if.slave (rate select, start/stop, preset, wrap limit in;
//           tick, load/clear strobes, digit, wrap count, state, load error out)
// All outputs are registered; strobes last exactly one cycle.
module count_ctrl #(
    parameter int unsigned DIV0 = 50000000,
    parameter int unsigned DIV1 = 5000000,
    parameter int unsigned DIV2 = 500000,
    parameter int unsigned DIV3 = 1
) (
    input  logic          CLK,
    input  logic          rst_n,
    count_ctrl_if.slave   bus
);

    localparam int unsigned PW = 26;
    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   digit_q, digit_d;
    logic [DW-1:0]   wrap_q, wrap_d;
    logic [DW-1:0]   load_cnt_q, load_cnt_d;
    logic            tick_q, tick_d;
    logic            load_en_q, load_en_d;
    logic            clr_q, clr_d;
    logic            err_q, err_d;

    logic [PW-1:0]   div_m1;
    logic            tick_due;
    logic [DW-1:0]   wrap_inc;
    logic            load_window;

    // Terminal prescaler value for the selected rate; re-evaluated every cycle so
    // a rate change applies at the next compare.
    always_comb begin
        div_m1 = PW'(DIV0 - 1);
        unique case (bus.contral)
            2'd0: div_m1 = PW'(DIV0 - 1);
            2'd1: div_m1 = PW'(DIV1 - 1);
            2'd2: div_m1 = PW'(DIV2 - 1);
            2'd3: div_m1 = PW'(DIV3 - 1);
            default: div_m1 = PW'(DIV0 - 1);
        endcase
    end

    // >= rather than == so a prescaler already past a newly shortened period ticks at once.
    assign tick_due = (presc_q >= div_m1);
    assign wrap_inc = (wrap_q == 4'hF) ? 4'hF : wrap_q + 4'd1;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        digit_d     = digit_q;
        wrap_d      = wrap_q;
        load_cnt_d  = load_cnt_q;
        tick_d      = 1'b0;
        load_en_d   = 1'b0;
        clr_d       = 1'b0;
        err_d       = 1'b0;
        load_window = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    wrap_d  = '0;
                end else begin
                    load_window = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    // Pause swallows a tick due this cycle; prescaler is kept for resume.
                    state_d = S_PAUSE;
                end else if (tick_due) begin
                    tick_d  = 1'b1;
                    presc_d = '0;
                    if (digit_q == 4'd9) begin
                        digit_d = '0;
                        wrap_d  = wrap_inc;
                        if ((bus.wrap_limit != 4'd0) && (wrap_inc == bus.wrap_limit)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        digit_d = digit_q + 4'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    digit_d = '0;
                end else if (bus.start) begin
                    state_d = S_RUN;
                end else begin
                    load_window = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    digit_d = '0;
                end else if (bus.start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    wrap_d  = '0;
                end else begin
                    load_window = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Preset only when idle-ish and no start/stop is being acted on.
        if (load_window && bus.load_req) begin
            if (bus.load_value <= 4'd9) begin
                load_en_d  = 1'b1;
                load_cnt_d = bus.load_value;
                digit_d    = bus.load_value;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            digit_q    <= '0;
            wrap_q     <= '0;
            load_cnt_q <= '0;
            tick_q     <= 1'b0;
            load_en_q  <= 1'b0;
            clr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            wrap_q     <= wrap_d;
            load_cnt_q <= load_cnt_d;
            tick_q     <= tick_d;
            load_en_q  <= load_en_d;
            clr_q      <= clr_d;
            err_q      <= err_d;
        end
    end

    assign bus.tick         = tick_q;
    assign bus.load_enable  = load_en_q;
    assign bus.load_counter = load_cnt_q;
    assign bus.cnt_clr      = clr_q;
    assign bus.digit        = digit_q;
    assign bus.wrap_cnt     = wrap_q;
    assign bus.state        = state_q;
    assign bus.load_err     = err_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed self-checking bench for count_ctrl with small dividers.
module tb_count_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    count_ctrl_if bus();

    count_ctrl #(
        .DIV0(8),
        .DIV1(4),
        .DIV2(2),
        .DIV3(1)
    ) dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_idle_zero(input string tag);
        check({tag, ".state"},   32'(bus.state), 0);
        check({tag, ".tick"},    32'(bus.tick), 0);
        check({tag, ".digit"},   32'(bus.digit), 0);
        check({tag, ".wrap"},    32'(bus.wrap_cnt), 0);
        check({tag, ".ldcnt"},   32'(bus.load_counter), 0);
        check({tag, ".ld_en"},   32'(bus.load_enable), 0);
        check({tag, ".clr"},     32'(bus.cnt_clr), 0);
        check({tag, ".ld_err"},  32'(bus.load_err), 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n          = 1'b0;
        bus.contral    = 2'd0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.load_req   = 1'b0;
        bus.load_value = 4'd0;
        bus.wrap_limit = 4'd0;

        #3;
        check_all_idle_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst.state", 32'(bus.state), 0);

        // Presets in IDLE: valid, invalid, boundary 9 and 10, then clear to 0.
        bus.load_req = 1'b1; bus.load_value = 4'd7;
        step();
        check("ld7.en", 32'(bus.load_enable), 1);
        check("ld7.cnt", 32'(bus.load_counter), 7);
        check("ld7.digit", 32'(bus.digit), 7);
        check("ld7.state", 32'(bus.state), 0);
        bus.load_value = 4'd12;
        step();
        check("ld12.en", 32'(bus.load_enable), 0);
        check("ld12.err", 32'(bus.load_err), 1);
        check("ld12.digit", 32'(bus.digit), 7);
        check("ld12.cnt", 32'(bus.load_counter), 7);
        bus.load_value = 4'd9;
        step();
        check("ld9.en", 32'(bus.load_enable), 1);
        check("ld9.err", 32'(bus.load_err), 0);
        check("ld9.digit", 32'(bus.digit), 9);
        bus.load_value = 4'd10;
        step();
        check("ld10.err", 32'(bus.load_err), 1);
        check("ld10.digit", 32'(bus.digit), 9);
        bus.load_value = 4'd0;
        step();
        check("ld0.digit", 32'(bus.digit), 0);
        bus.load_req = 1'b0;
        step();
        check("ld_off.en", 32'(bus.load_enable), 0);
        check("ld_off.err", 32'(bus.load_err), 0);

        // contral=01: tick every 4th cycle, one wrap after 40 cycles; load in RUN ignored.
        bus.contral = 2'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("r1.state", 32'(bus.state), 1);
        check("r1.tick0", 32'(bus.tick), 0);
        for (int c = 1; c <= 40; c++) begin
            bus.load_req   = (c == 10);
            bus.load_value = 4'd3;
            step();
            check($sformatf("r1.tick[%0d]", c), 32'(bus.tick), ((c % 4) == 0) ? 1 : 0);
            check($sformatf("r1.digit[%0d]", c), 32'(bus.digit), 32'((c / 4) % 10));
            check($sformatf("r1.ld_en[%0d]", c), 32'(bus.load_enable), 0);
        end
        bus.load_req = 1'b0;
        check("r1.wrap", 32'(bus.wrap_cnt), 1);
        check("r1.state_end", 32'(bus.state), 1);

        // Pause, then start+stop together in PAUSE: stop wins, clear pulse.
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("p1.state", 32'(bus.state), 2);
        check("p1.tick", 32'(bus.tick), 0);
        bus.start = 1'b1; bus.stop = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("ss.state", 32'(bus.state), 0);
        check("ss.clr", 32'(bus.cnt_clr), 1);
        check("ss.digit", 32'(bus.digit), 0);
        step();
        check("ss.clr_off", 32'(bus.cnt_clr), 0);
        check("ss.wrap_kept", 32'(bus.wrap_cnt), 1);

        // wrap_limit=2 at full rate: 20 ticks then DONE, no 21st tick.
        bus.contral = 2'd3; bus.wrap_limit = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("wl.state", 32'(bus.state), 1);
        check("wl.wrap0", 32'(bus.wrap_cnt), 0);
        for (int c = 1; c <= 21; c++) begin
            step();
            check($sformatf("wl.tick[%0d]", c), 32'(bus.tick), (c <= 20) ? 1 : 0);
            check($sformatf("wl.digit[%0d]", c), 32'(bus.digit), (c <= 20) ? 32'(c % 10) : 0);
            check($sformatf("wl.state[%0d]", c), 32'(bus.state), (c >= 20) ? 3 : 1);
            check($sformatf("wl.wrap[%0d]", c), 32'(bus.wrap_cnt),
                  (c >= 20) ? 2 : ((c >= 10) ? 1 : 0));
        end

        // DONE: preset accepted, stop clears to IDLE.
        bus.load_req = 1'b1; bus.load_value = 4'd5;
        step();
        bus.load_req = 1'b0;
        check("dn.ld_en", 32'(bus.load_enable), 1);
        check("dn.digit", 32'(bus.digit), 5);
        check("dn.state", 32'(bus.state), 3);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("dn.stop_state", 32'(bus.state), 0);
        check("dn.clr", 32'(bus.cnt_clr), 1);
        check("dn.digit0", 32'(bus.digit), 0);

        // start with load_req in same cycle: load ignored, RUN entered.
        bus.wrap_limit = 4'd0;
        bus.start = 1'b1; bus.load_req = 1'b1; bus.load_value = 4'd2;
        step();
        bus.start = 1'b0; bus.load_req = 1'b0;
        check("sl.state", 32'(bus.state), 1);
        check("sl.ld_en", 32'(bus.load_enable), 0);
        check("sl.digit", 32'(bus.digit), 0);
        step();
        check("sl.tick", 32'(bus.tick), 1);
        check("sl.digit1", 32'(bus.digit), 1);
        // Tick due every cycle; stop must suppress it.
        bus.stop = 1'b1;
        step();
        check("sp.tick", 32'(bus.tick), 0);
        check("sp.state", 32'(bus.state), 2);
        check("sp.digit", 32'(bus.digit), 1);
        step();
        bus.stop = 1'b0;
        check("sp.idle", 32'(bus.state), 0);
        check("sp.clr", 32'(bus.cnt_clr), 1);

        // contral=00: stop on the due cycle, resume ticks on the next cycle.
        bus.contral = 2'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("s0.state", 32'(bus.state), 1);
        for (int c = 1; c <= 7; c++) begin
            step();
            check($sformatf("s0.tick[%0d]", c), 32'(bus.tick), 0);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("s0.stop_tick", 32'(bus.tick), 0);
        check("s0.stop_state", 32'(bus.state), 2);
        check("s0.stop_digit", 32'(bus.digit), 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("s0.resume_state", 32'(bus.state), 1);
        check("s0.resume_tick0", 32'(bus.tick), 0);
        step();
        check("s0.resume_tick", 32'(bus.tick), 1);
        check("s0.resume_digit", 32'(bus.digit), 1);

        // Rate change mid-count: prescaler at 3 already meets DIV1-1.
        step(); step(); step();
        check("rc.tick_pre", 32'(bus.tick), 0);
        bus.contral = 2'd1;
        step();
        check("rc.tick", 32'(bus.tick), 1);
        check("rc.digit", 32'(bus.digit), 2);

        // Asynchronous reset between edges while ticking every cycle.
        bus.contral = 2'd3;
        step();
        check("ar.tick_pre", 32'(bus.tick), 1);
        check("ar.digit_pre", 32'(bus.digit), 3);
        #2 rst_n = 1'b0;
        #1;
        check_all_idle_zero("async_rst");
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("ar.tick[%0d]", c), 32'(bus.tick), 0);
            check($sformatf("ar.state[%0d]", c), 32'(bus.state), 0);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ar.start_state", 32'(bus.state), 1);
        step();
        check("ar.start_tick", 32'(bus.tick), 1);
        check("ar.start_digit", 32'(bus.digit), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
